// File: rtl/cla_serial_adder_if.sv
// cla_serial_adder_if: operand/result handshake bundle for the nibble-serial adder
interface cla_serial_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/cla_serial_adder.sv
// cla_serial_adder: WIDTH-bit adder built from one cla_4bit slice reused once per nibble
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g, p;
    logic [4:0] c;
    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s    = p ^ c[3:0];
    assign co   = c[4];
endmodule

module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                clk,
    input logic                rst,
    cla_serial_adder_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("cla_serial_adder: WIDTH must be a positive multiple of 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nxt, sum_r;
    logic [CW-1:0]    cnt;
    logic             cy, cout_r, ovf_r, ov_r, a_msb, b_msb;
    logic [3:0]       ss;
    logic             sc;
    logic             acc, last;

    cla_4bit u_slice (.a(a_sr[3:0]), .b(b_sr[3:0]), .ci(cy), .s(ss), .co(sc));

    // New nibble enters at the top so the first (LSB) nibble lands at [3:0] after NIB passes.
    assign s_nxt = (s_sr >> 4) | (WIDTH'(ss) << (WIDTH - 4));
    assign acc   = bus.in_valid && state == IDLE;
    assign last  = cnt == CW'(NIB - 1);

    always_comb begin
        nxt = state == IDLE ? (acc ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : (bus.out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            ov_r   <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            state <= nxt;
            if (acc) begin
                a_sr  <= bus.a;
                b_sr  <= bus.b;
                cy    <= bus.cin;
                a_msb <= bus.a[WIDTH-1];
                b_msb <= bus.b[WIDTH-1];
                cnt   <= '0;
            end
            if (state == RUN) begin
                a_sr <= a_sr >> 4;
                b_sr <= b_sr >> 4;
                s_sr <= s_nxt;
                cy   <= sc;
                cnt  <= cnt + 1'b1;
            end
            // Visible results update only on the DONE-entry edge.
            if (state == RUN && last) begin
                sum_r  <= s_nxt;
                cout_r <= sc;
                ovf_r  <= (a_msb == b_msb) && (s_nxt[WIDTH-1] != a_msb);
                ov_r   <= 1'b1;
            end
            if (state == DONE && bus.out_ready) ov_r <= 1'b0;
        end
    end

    assign bus.in_ready  = state == IDLE && !rst;
    assign bus.out_valid = ov_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.overflow  = ovf_r;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_cla_serial_adder.sv
// tb_cla_serial_adder: directed and random checks of 16-bit and 4-bit instances against arithmetic reference
module tb_cla_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    cla_serial_adder_if #(.WIDTH(16)) i16 ();
    cla_serial_adder_if #(.WIDTH(4))  i4 ();

    cla_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));
    cla_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(i4));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer addition, then truncate and range-test the signed result.
    task automatic model(input int w, input logic [31:0] x, input logic [31:0] y, input logic c,
                         output logic [31:0] s, output logic co, output logic ov);
        longint t, sx, sy, st, half;
        half = longint'(1) << (w - 1);
        t    = longint'(x) + longint'(y) + longint'(c);
        s    = 32'(t & ((longint'(1) << w) - 1));
        co   = t[w];
        sx   = (longint'(x) >= half) ? longint'(x) - 2 * half : longint'(x);
        sy   = (longint'(y) >= half) ? longint'(y) - 2 * half : longint'(y);
        st   = sx + sy + longint'(c);
        ov   = st >= half || st < -half;
    endtask

    task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic c, input int hold);
        logic [31:0] es;
        logic        ec, eo;
        int          lat;
        model(16, 32'(x), 32'(y), c, es, ec, eo);
        i16.a = x; i16.b = y; i16.cin = c; i16.in_valid = 1'b1; i16.out_ready = 1'b0;
        step();
        i16.in_valid = 1'b0;
        lat = 0;
        while (!i16.out_valid && lat < 20) begin
            chk("w16 in_ready in RUN", 32'(i16.in_ready), 32'(0));
            i16.a = 16'($urandom); i16.b = 16'($urandom); i16.cin = 1'($urandom);
            step();
            lat++;
        end
        chk("w16 latency", 32'(lat), 32'(4));
        chk("w16 sum", 32'(i16.sum), es);
        chk("w16 cout", 32'(i16.cout), 32'(ec));
        chk("w16 overflow", 32'(i16.overflow), 32'(eo));
        chk("w16 busy DONE", 32'(i16.busy), 32'(1));
        repeat (hold) begin
            i16.in_valid = 1'($urandom);
            step();
            chk("w16 hold valid", 32'(i16.out_valid), 32'(1));
            chk("w16 hold sum", 32'(i16.sum), es);
            chk("w16 hold flags", {30'd0, i16.cout, i16.overflow}, {30'd0, ec, eo});
            chk("w16 hold in_ready", 32'(i16.in_ready), 32'(0));
        end
        i16.in_valid = 1'b0;
        i16.out_ready = 1'b1;
        step();
        i16.out_ready = 1'b0;
        chk("w16 valid clear", 32'(i16.out_valid), 32'(0));
        chk("w16 ready again", 32'(i16.in_ready), 32'(1));
        chk("w16 sum kept", 32'(i16.sum), es);
    endtask

    task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [31:0] es;
        logic        ec, eo;
        int          lat;
        model(4, 32'(x), 32'(y), c, es, ec, eo);
        i4.a = x; i4.b = y; i4.cin = c; i4.in_valid = 1'b1; i4.out_ready = 1'b0;
        step();
        i4.in_valid = 1'b0;
        lat = 0;
        while (!i4.out_valid && lat < 20) begin
            i4.a = 4'($urandom); i4.b = 4'($urandom);
            step();
            lat++;
        end
        chk("w4 latency", 32'(lat), 32'(1));
        chk("w4 sum", 32'(i4.sum), es);
        chk("w4 cout", 32'(i4.cout), 32'(ec));
        chk("w4 overflow", 32'(i4.overflow), 32'(eo));
        i4.out_ready = 1'b1;
        step();
        i4.out_ready = 1'b0;
        chk("w4 valid clear", 32'(i4.out_valid), 32'(0));
    endtask

    initial begin
        i16.in_valid = 0; i16.a = 0; i16.b = 0; i16.cin = 0; i16.out_ready = 0;
        i4.in_valid = 0;  i4.a = 0;  i4.b = 0;  i4.cin = 0;  i4.out_ready = 0;
        step();
        step();
        chk("rst in_ready", 32'(i16.in_ready), 32'(0));
        chk("rst out_valid", 32'(i16.out_valid), 32'(0));
        chk("rst sum", 32'(i16.sum), 32'(0));
        rst = 1'b0;
        #1;
        chk("idle in_ready", 32'(i16.in_ready), 32'(1));
        chk("idle busy", 32'(i16.busy), 32'(0));

        run16(16'h1234, 16'h4321, 1'b0, 0);
        run16(16'hFFFF, 16'h0001, 1'b0, 0);
        run16(16'h7FFF, 16'h0001, 1'b0, 1);
        run16(16'h8000, 16'h8000, 1'b1, 0);
        run16(16'h00FF, 16'h0F0F, 1'b1, 5);
        run16(16'hABCD, 16'h1111, 1'b0, 0);

        // Reset in the second RUN cycle discards the operation.
        i16.a = 16'h9999; i16.b = 16'h9999; i16.cin = 1'b1; i16.in_valid = 1'b1;
        step();
        i16.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid-run rst valid", 32'(i16.out_valid), 32'(0));
        chk("mid-run rst sum", 32'(i16.sum), 32'(0));
        chk("mid-run rst flags", {30'd0, i16.cout, i16.overflow}, 32'(0));
        chk("mid-run rst in_ready", 32'(i16.in_ready), 32'(1));
        chk("mid-run rst busy", 32'(i16.busy), 32'(0));
        run16(16'h0001, 16'h0002, 1'b0, 0);

        for (int i = 0; i < 8; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        run4(4'hF, 4'hF, 1'b1);
        run4(4'h8, 4'h8, 1'b0);
        run4(4'h7, 4'h7, 1'b0);
        for (int i = 0; i < 4; i++)
            run4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
